wdata_chan_mngr: RTL and testbench
==================================

WDATA_CHAN_MNGR -- requirements
Module: wdata_chan_mngr

Interface
REQ-001 SHALL have ports: clk  input  1  clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-002 SHALL have: start_wd  input  1  burst request; start_id  input  4  transaction ID; start_len  input  8  beats minus one.
REQ-003 SHALL have: start_ready  output  1  request accepted when high with start_wd.
REQ-004 SHALL have: src_valid  input  1; src_data  input  32; src_strb  input  4; src_ready  output  1  (data source handshake).
REQ-005 SHALL have: wvalid  output  1; wready  input  1; wdata  output  32; wstrb  output  4; wid  output  4; wlast  output  1  (bus write data channel).
REQ-006 SHALL have: finish_wd  output  1  last beat accepted; finish_id  output  4  ID of finished burst; finish_wresp  input  1  response accepted by response manager.
REQ-007 SHALL have: busy_wd  output  1  high whenever state is not IDLE.

Function
REQ-008 SHALL implement states IDLE, DATA, WRESP (2-bit encoding); any unused encoding SHALL return to IDLE next cycle.
REQ-009 start_ready SHALL equal (state==IDLE); start_wd while not IDLE SHALL be ignored, with no latch update.
REQ-010 On start_wd & start_ready: latch start_id into id_lat, start_len into len_lat; clear fetch_cnt and beat_cnt; go to DATA.
REQ-011 Output stage SHALL be one register (wdata, wstrb, wvalid); wvalid high only while the register holds an unsent beat.
REQ-012 src_ready SHALL equal (state==DATA) & (fetch_cnt <= len_lat) & (~wvalid | wready), combinationally.
REQ-013 On src_valid & src_ready: load src_data/src_strb into the register, set wvalid, increment fetch_cnt (9-bit, no wrap).
REQ-014 On wvalid & wready with no load in the same cycle: clear wvalid; with a simultaneous load, wvalid SHALL stay high (back-to-back, 1 beat/cycle).
REQ-015 On wvalid & wready: increment beat_cnt (9-bit).
REQ-016 wid SHALL equal id_lat; wlast SHALL equal wvalid & (beat_cnt == len_lat).
REQ-017 finish_wd SHALL be combinational wvalid & wready & wlast: exactly one cycle per burst. finish_id SHALL equal id_lat.
REQ-018 DATA -> WRESP on finish_wd; wvalid SHALL be 0 in WRESP.
REQ-019 WRESP -> IDLE on finish_wresp; a new start is accepted no earlier than the cycle after finish_wresp, so at most one response is outstanding.
REQ-020 finish_wresp outside WRESP SHALL be ignored.
REQ-021 wdata/wstrb SHALL hold stable while wvalid & ~wready.
REQ-022 start_len=0 SHALL produce a single beat with wlast=1 on that beat.
REQ-023 start_len=255 SHALL produce 256 beats; counters SHALL not overflow.
REQ-024 Latency: first wvalid SHALL be 1 cycle after the first src handshake; the src handshake SHALL be possible in the cycle after the start is accepted.

Reset
REQ-025 On rst_n low, at any time including mid-burst: state=IDLE, wvalid=0, wdata=0, wstrb=0, id_lat=0, len_lat=0, fetch_cnt=0, beat_cnt=0.
REQ-026 Hence after reset: src_ready=0, wlast=0, finish_wd=0, finish_id=0, wid=0, busy_wd=0, start_ready=1.
REQ-027 After reset release the block SHALL accept a start on the first clock edge.

Verification
REQ-028 start_wd, id=5, len=3, src_valid and wready always high -> 4 consecutive beats, wlast on the 4th, finish_wd=1 with finish_id=5 in that cycle; busy_wd held until finish_wresp.
REQ-029 len=0, id=9 -> one beat with wlast=1, finish_wd/finish_id=9; then finish_wresp -> IDLE and start_ready=1 the next cycle.
REQ-030 wready low for 3 cycles mid-burst (len=7) -> wdata/wstrb stable, src_ready=0, no beat lost or duplicated; 8 beats total in order.
REQ-031 start_wd asserted in DATA and in WRESP -> ignored, id_lat unchanged; finish_wresp pulsed in DATA -> no state change.
REQ-032 rst_n asserted at beat 2 of len=7 -> all outputs at reset values immediately; a new burst id=3, len=1 runs cleanly after release.
REQ-033 len=255 with random src_valid/wready gaps -> exactly 256 beats, data order preserved, a single finish_wd.

Source files
------------

// File: rtl/wdata_chan_mngr.sv
// Write-data channel manager: pulls burst beats from a source into a single
// output register, drives the bus W channel and waits for the response before idling.
module wdata_chan_mngr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_wd,
  input  logic [3:0]  start_id,
  input  logic [7:0]  start_len,
  output logic        start_ready,
  input  logic        src_valid,
  input  logic [31:0] src_data,
  input  logic [3:0]  src_strb,
  output logic        src_ready,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [3:0]  wid,
  output logic        wlast,
  output logic        finish_wd,
  output logic [3:0]  finish_id,
  input  logic        finish_wresp,
  output logic        busy_wd,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid never waits for ready, and payload holds while valid & ~ready.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    WRESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  id_q, id_d;
  logic [7:0]  len_q, len_d;
  logic [8:0]  fetch_cnt_q, fetch_cnt_d;
  logic [8:0]  beat_cnt_q, beat_cnt_d;
  logic        wvalid_q, wvalid_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic start_acc;
  logic load;
  logic send;

  assign start_ready = (state_q == IDLE);
  assign start_acc   = start_wd & start_ready;
  // 9-bit compare so a 256-beat burst stops fetching after the last beat.
  assign src_ready   = (state_q == DATA) & (fetch_cnt_q <= {1'b0, len_q}) & (~wvalid_q | wready);
  assign load        = src_valid & src_ready;
  assign send        = wvalid_q & wready;

  assign wvalid      = wvalid_q;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;
  assign wid         = id_q;
  assign wlast       = wvalid_q & (beat_cnt_q == {1'b0, len_q});
  assign finish_wd   = send & wlast;
  assign finish_id   = id_q;
  assign busy_wd     = (state_q != IDLE);
  assign dbg_state_o = state_q;

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = start_wd ? DATA : IDLE;
      DATA:    state_d = finish_wd ? WRESP : DATA;
      WRESP:   state_d = finish_wresp ? IDLE : WRESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    id_d        = id_q;
    len_d       = len_q;
    fetch_cnt_d = fetch_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    wvalid_d    = wvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    if (start_acc) begin
      id_d        = start_id;
      len_d       = start_len;
      fetch_cnt_d = 9'd0;
      beat_cnt_d  = 9'd0;
    end else begin
      if (send) begin
        beat_cnt_d = beat_cnt_q + 9'd1;
        wvalid_d   = 1'b0;
      end
      // A load in the same cycle as a send keeps wvalid high for back-to-back beats.
      if (load) begin
        fetch_cnt_d = fetch_cnt_q + 9'd1;
        wvalid_d    = 1'b1;
        wdata_d     = src_data;
        wstrb_d     = src_strb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      id_q        <= 4'd0;
      len_q       <= 8'd0;
      fetch_cnt_q <= 9'd0;
      beat_cnt_q  <= 9'd0;
      wvalid_q    <= 1'b0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      len_q       <= len_d;
      fetch_cnt_q <= fetch_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      wvalid_q    <= wvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
    end
  end

endmodule

// File: tb/tb_wdata_chan_mngr.sv
// Bench for wdata_chan_mngr: random source/bus traffic compared every cycle
// against a queue-based model of the burst, plus literal checks per scenario.
module tb_wdata_chan_mngr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_wd = 1'b0;
  logic [3:0]  start_id = 4'd0;
  logic [7:0]  start_len = 8'd0;
  logic        start_ready;
  logic        src_valid = 1'b0;
  logic [31:0] src_data = 32'd0;
  logic [3:0]  src_strb = 4'd0;
  logic        src_ready;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [3:0]  wid;
  logic        wlast;
  logic        finish_wd;
  logic [3:0]  finish_id;
  logic        finish_wresp = 1'b0;
  logic        busy_wd;
  logic [1:0]  dbg_state;

  wdata_chan_mngr dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_wd     (start_wd),
    .start_id     (start_id),
    .start_len    (start_len),
    .start_ready  (start_ready),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_strb     (src_strb),
    .src_ready    (src_ready),
    .wvalid       (wvalid),
    .wready       (wready),
    .wdata        (wdata),
    .wstrb        (wstrb),
    .wid          (wid),
    .wlast        (wlast),
    .finish_wd    (finish_wd),
    .finish_id    (finish_id),
    .finish_wresp (finish_wresp),
    .busy_wd      (busy_wd),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_chk = 0;
  int n_pass = 0;
  int sv_pct = 0;
  int wr_pct = 0;

  task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Phase 0 idle, 1 moving data, 2 awaiting response. exp_q holds the beat
  // currently offered on the bus (accepted from the source but not yet sent).
  logic [35:0] exp_q[$];
  logic [35:0] m_reg;
  logic [3:0]  m_id;
  int          m_ph, m_len, m_fetched, m_sent;

  int cyc = 0;
  int n_sent = 0;
  int n_fin = 0;
  int acc_cyc = 0;
  int first_send_cyc = 0;
  int last_send_cyc = 0;
  bit seen_send = 1'b0;
  logic [3:0] last_fin_id = 4'd0;

  initial begin : compare
    logic [35:0] er;
    bit e_v, e_sr, e_last, e_fin, snd, ld;
    m_ph = 0; m_len = 0; m_fetched = 0; m_sent = 0; m_id = 4'd0; m_reg = 36'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_ph = 0; m_len = 0; m_fetched = 0; m_sent = 0; m_id = 4'd0; m_reg = 36'd0;
        exp_q.delete();
      end
      e_v    = (exp_q.size() != 0);
      er     = e_v ? exp_q[0] : m_reg;
      e_sr   = (m_ph == 1) && (m_fetched <= m_len) && (!e_v || wready);
      e_last = e_v && (m_sent == m_len);
      e_fin  = e_v && wready && e_last;
      check("start_ready", start_ready, m_ph == 0);
      check("src_ready", src_ready, e_sr);
      check("wvalid", wvalid, e_v);
      check("wdata", wdata, er[31:0]);
      check("wstrb", wstrb, er[35:32]);
      check("wid", wid, m_id);
      check("wlast", wlast, e_last);
      check("finish_wd", finish_wd, e_fin);
      check("finish_id", finish_id, m_id);
      check("busy_wd", busy_wd, m_ph != 0);
      // observation counters for the literal checks
      if (rst_n && start_wd && start_ready) begin
        acc_cyc = cyc;
        seen_send = 1'b0;
      end
      if (wvalid && wready) begin
        if (!seen_send) first_send_cyc = cyc;
        seen_send = 1'b1;
        last_send_cyc = cyc;
        n_sent++;
      end
      if (finish_wd) begin
        n_fin++;
        last_fin_id = finish_id;
      end
      if (rst_n) begin
        snd = e_v && wready;
        ld  = src_valid && e_sr;
        if (snd) begin
          void'(exp_q.pop_front());
          m_sent++;
        end
        if (ld) begin
          exp_q.push_back({src_strb, src_data});
          m_reg = {src_strb, src_data};
          m_fetched++;
        end
        case (m_ph)
          0: if (start_wd) begin
               m_ph = 1; m_id = start_id; m_len = int'(start_len);
               m_fetched = 0; m_sent = 0;
             end
          1: if (e_fin) m_ph = 2;
          2: if (finish_wresp) m_ph = 0;
          default: m_ph = 0;
        endcase
      end
    end
  end

  // ---------------- random source / sink driver ----------------
  initial begin : rand_drv
    forever begin
      @(posedge clk);
      #2;
      src_valid = ($urandom_range(99) < sv_pct);
      src_data  = $urandom;
      src_strb  = 4'($urandom_range(15));
      wready    = ($urandom_range(99) < wr_pct);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_burst(input logic [3:0] id, input logic [7:0] len, input int sv,
                           input int wr, input int stall_at, input bit poke, input bit started);
    int  s0, f0;
    bit  done, stalled;
    s0 = n_sent;
    f0 = n_fin;
    done = 1'b0;
    stalled = 1'b0;
    sv_pct = sv;
    wr_pct = wr;
    if (!started) begin
      @(posedge clk); #1;
      start_wd = 1'b1; start_id = id; start_len = len;
      @(posedge clk); #1;
      start_wd = 1'b0;
    end
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (poke && i == 0) begin
        start_wd = 1'b1; start_id = ~id; start_len = 8'd9; finish_wresp = 1'b1;
      end
      if (poke && i == 1) begin
        start_wd = 1'b0; finish_wresp = 1'b0;
      end
      if (n_fin != f0) begin
        done = 1'b1;
        break;
      end
      if (stall_at >= 0 && !stalled && (n_sent - s0) >= stall_at) begin
        stalled = 1'b1;
        wr_pct = 0;
        repeat (3) @(posedge clk);
        #1 wr_pct = wr;
      end
    end
    start_wd = 1'b0;
    finish_wresp = 1'b0;
    check("burst_done_in_budget", done, 1'b1);
    if (poke) begin
      start_wd = 1'b1; start_id = ~id;
      @(posedge clk); #1;
      start_wd = 1'b0;
    end
    repeat ($urandom_range(2)) begin
      @(posedge clk); #1;
    end
    finish_wresp = 1'b1;
    @(posedge clk); #1;
    finish_wresp = 1'b0;
    @(negedge clk); #1;
    check("idle_after_resp", start_ready, 1'b1);
    check("beats_per_burst", n_sent - s0, int'(len) + 1);
    check("finish_per_burst", n_fin - f0, 1);
    check("finish_id_lit", last_fin_id, id);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int b0;
    bit got;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // id=5 len=3, everything always ready
    run_burst(4'd5, 8'd3, 100, 100, -1, 1'b0, 1'b0);
    check("first_beat_latency", first_send_cyc - acc_cyc, 2);
    check("beats_consecutive", last_send_cyc - first_send_cyc, 3);

    // single-beat burst
    run_burst(4'd9, 8'd0, 100, 100, -1, 1'b0, 1'b0);
    check("single_beat_latency", first_send_cyc - acc_cyc, 2);

    // 3-cycle bus stall mid-burst
    run_burst(4'd6, 8'd7, 100, 100, 3, 1'b0, 1'b0);

    // stray start/response pulses while busy
    run_burst(4'd4, 8'd4, 100, 100, -1, 1'b1, 1'b0);

    // reset in the middle of a burst
    sv_pct = 100; wr_pct = 100;
    b0 = n_sent;
    got = 1'b0;
    @(posedge clk); #1;
    start_wd = 1'b1; start_id = 4'd2; start_len = 8'd7;
    @(posedge clk); #1;
    start_wd = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (n_sent - b0 >= 2) begin
        got = 1'b1;
        break;
      end
    end
    check("reach_beat2", got, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_wstrb", wstrb, 4'd0);
    check("rst_src_ready", src_ready, 1'b0);
    check("rst_wlast", wlast, 1'b0);
    check("rst_finish_wd", finish_wd, 1'b0);
    check("rst_finish_id", finish_id, 4'd0);
    check("rst_wid", wid, 4'd0);
    check("rst_busy", busy_wd, 1'b0);
    check("rst_start_ready", start_ready, 1'b1);
    check("rst_state", dbg_state, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_wd = 1'b1; start_id = 4'd3; start_len = 8'd1;
    @(posedge clk); #1;
    start_wd = 1'b0;
    check("accept_first_edge", busy_wd, 1'b1);
    run_burst(4'd3, 8'd1, 100, 100, -1, 1'b0, 1'b1);

    // random bursts
    for (int k = 0; k < 8; k++) begin
      run_burst(4'($urandom_range(15)), 8'($urandom_range(30)),
                $urandom_range(30, 100), $urandom_range(30, 100), -1, 1'b0, 1'b0);
    end

    // longest burst with gaps on both sides
    run_burst(4'd10, 8'd255, 70, 70, -1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
